// File: rtl/rx_udp_packer_pkg.sv
// Shared constants for the RX UDP word packer: octet width, FSM encodings
// and the bit layout of one FIFO entry {last, bytes-1, data}.
package rx_udp_packer_pkg;

  localparam int OCT    = 8;
  localparam int WORD_W = 4 * OCT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PACK = 2'b01,
    ST_DROP = 2'b11
  } state_t;

  localparam int ENT_DATA_LSB  = 0;
  localparam int ENT_DATA_MSB  = WORD_W - 1;
  localparam int ENT_BYTES_LSB = WORD_W;
  localparam int ENT_BYTES_MSB = WORD_W + 1;
  localparam int ENT_LAST      = WORD_W + 2;
  localparam int ENT_W         = WORD_W + 3;

endpackage

// File: rtl/rx_word_fifo_mem.sv
// Simple dual-port word store: registered write, asynchronous read.
module rx_word_fifo_mem #(
  parameter int ADDR_W = 6,
  parameter int W      = 35
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_udp_packer.sv
// Packs the rx_udp byte stream into 32-bit little-endian words and commits
// each datagram atomically; datagrams that do not fit are rolled back whole.
module rx_udp_packer
  import rx_udp_packer_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              RX_CLK,
  input  logic              rst,
  input  logic              rx_udp_data_v,
  input  logic [OCT-1:0]    rx_udp_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic [1:0]        rd_bytes,
  output logic              frame_irq,
  output logic [15:0]       frames_ok,
  output logic [15:0]       frames_drop
);

  localparam int             DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  state_t state_q, state_d;

  logic [ADDR_W:0]   wr_ptr_q, cm_ptr_q, rd_ptr_q;
  logic [WORD_W-1:0] stage_q;
  logic [1:0]        bidx_q;
  logic              stage_full_q;

  logic              fifo_full;
  logic              pop;
  logic              mem_we;
  logic [ENT_W-1:0]  mem_wdata;
  logic [ENT_W-1:0]  mem_rdata;
  logic              do_start, do_insert, do_commit, do_drop;
  logic [1:0]        last_bytes;

  // Full uses rd_ptr before any pop this cycle, so a same-cycle pop never helps.
  assign fifo_full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign rd_valid   = rd_ptr_q != cm_ptr_q;
  assign pop        = rd_valid && rd_ready;
  assign last_bytes = stage_full_q ? 2'd3 : bidx_q - 2'd1;

  // State register
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rx_udp_data_v) state_d = ST_PACK;
      ST_PACK: begin
        if (rx_udp_data_v) begin
          if (stage_full_q && fifo_full) state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: if (!rx_udp_data_v) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    do_start  = 1'b0;
    do_insert = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: do_start = rx_udp_data_v;
      ST_PACK: begin
        if (rx_udp_data_v) begin
          if (stage_full_q) begin
            if (fifo_full) begin
              do_drop = 1'b1;
            end else begin
              mem_we   = 1'b1;
              do_start = 1'b1;
              mem_wdata[ENT_LAST]                    = 1'b0;
              mem_wdata[ENT_BYTES_MSB:ENT_BYTES_LSB] = 2'd3;
              mem_wdata[ENT_DATA_MSB:ENT_DATA_LSB]   = stage_q;
            end
          end else begin
            do_insert = 1'b1;
          end
        end else if (fifo_full) begin
          // End of datagram with no room for its final word.
          do_drop = 1'b1;
        end else begin
          mem_we    = 1'b1;
          do_commit = 1'b1;
          mem_wdata[ENT_LAST]                    = 1'b1;
          mem_wdata[ENT_BYTES_MSB:ENT_BYTES_LSB] = last_bytes;
          mem_wdata[ENT_DATA_MSB:ENT_DATA_LSB]   = stage_q;
        end
      end
      default: ;
    endcase
  end

  // Pointers, staging register and counters
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      stage_q      <= '0;
      bidx_q       <= '0;
      stage_full_q <= 1'b0;
      frame_irq    <= 1'b0;
      frames_ok    <= '0;
      frames_drop  <= '0;
    end else begin
      frame_irq <= do_commit;

      if (mem_we) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_commit) begin
        cm_ptr_q  <= wr_ptr_q + PTR_ONE;
        frames_ok <= frames_ok + 16'd1;
      end
      if (do_drop) begin
        wr_ptr_q <= cm_ptr_q;
        if (frames_drop != 16'hFFFF) frames_drop <= frames_drop + 16'd1;
      end

      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;

      // Clearing the staging word keeps unused lanes of a short word at zero.
      if (do_start) begin
        stage_q      <= {{(WORD_W - OCT){1'b0}}, rx_udp_data};
        bidx_q       <= 2'd1;
        stage_full_q <= 1'b0;
      end else if (do_insert) begin
        stage_q[bidx_q * OCT +: OCT] <= rx_udp_data;
        bidx_q                       <= bidx_q + 2'd1;
        if (bidx_q == 2'd3) stage_full_q <= 1'b1;
      end else if (do_commit || do_drop) begin
        stage_q      <= '0;
        bidx_q       <= '0;
        stage_full_q <= 1'b0;
      end
    end
  end

  rx_word_fifo_mem #(
    .ADDR_W (ADDR_W),
    .W      (ENT_W)
  ) u_mem (
    .clk   (RX_CLK),
    .we    (mem_we),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  assign rd_data  = rd_valid ? mem_rdata[ENT_DATA_MSB:ENT_DATA_LSB]   : '0;
  assign rd_bytes = rd_valid ? mem_rdata[ENT_BYTES_MSB:ENT_BYTES_LSB] : 2'd0;
  assign rd_last  = rd_valid ? mem_rdata[ENT_LAST]                    : 1'b0;

endmodule

// File: tb/tb_rx_udp_packer.sv
// Directed bench for rx_udp_packer: a 4-word and a 64-word instance share the
// same byte stream and consumer, each with its own expected-word queue.
module tb_rx_udp_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_v;
  logic [7:0] rx_d;
  logic       rd_ready;
  logic       toggle;

  logic        rd_valid_a, rd_last_a, irq_a;
  logic [31:0] rd_data_a;
  logic [1:0]  rd_bytes_a;
  logic [15:0] ok_a, drop_a;

  logic        rd_valid_b, rd_last_b, irq_b;
  logic [31:0] rd_data_b;
  logic [1:0]  rd_bytes_b;
  logic [15:0] ok_b, drop_b;

  rx_udp_packer #(.ADDR_W(2)) dut_a (
    .RX_CLK(clk), .rst(rst), .rx_udp_data_v(rx_v), .rx_udp_data(rx_d),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
    .rd_last(rd_last_a), .rd_bytes(rd_bytes_a), .frame_irq(irq_a),
    .frames_ok(ok_a), .frames_drop(drop_a)
  );

  rx_udp_packer #(.ADDR_W(6)) dut_b (
    .RX_CLK(clk), .rst(rst), .rx_udp_data_v(rx_v), .rx_udp_data(rx_d),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
    .rd_last(rd_last_b), .rd_bytes(rd_bytes_b), .frame_irq(irq_b),
    .frames_ok(ok_b), .frames_drop(drop_b)
  );

  // Scoreboard: entries are {last, bytes-1, data}
  logic [34:0] exp_a[$];
  logic [34:0] exp_b[$];
  int total = 0;
  int bad   = 0;
  int irq_cnt_a = 0;
  int irq_cnt_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, req);
    end
  endtask

  function automatic logic [34:0] ent(input logic last, input logic [1:0] nb, input logic [31:0] d);
    return {last, nb, d};
  endfunction

  // Monitors: a word is consumed at the next rising edge when valid && ready
  always @(negedge clk) begin
    if (!rst && rd_valid_a && rd_ready) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL word_a unexpected got=%h expected=none", {rd_last_a, rd_bytes_a, rd_data_a});
      end else begin
        check("word_a", {29'd0, rd_last_a, rd_bytes_a, rd_data_a}, {29'd0, exp_a.pop_front()});
      end
    end
    if (!rst && rd_valid_b && rd_ready) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL word_b unexpected got=%h expected=none", {rd_last_b, rd_bytes_b, rd_data_b});
      end else begin
        check("word_b", {29'd0, rd_last_b, rd_bytes_b, rd_data_b}, {29'd0, exp_b.pop_front()});
      end
    end
    if (!rst && irq_a) irq_cnt_a++;
    if (!rst && irq_b) irq_cnt_b++;
  end

  // Driver tasks
  task automatic step();
    if (toggle) rd_ready = ~rd_ready;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      rx_v = 1'b1;
      rx_d = b[i];
      step();
    end
    rx_v = 1'b0;
    rx_d = 8'h00;
    repeat (gap) step();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout left_a=%0d left_b=%0d expected=0", exp_a.size(), exp_b.size());
      exp_a.delete();
      exp_b.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int eok_a, input int edrop_a,
                              input int eok_b, input int edrop_b);
    check({tag, "_ok_a"},   {48'd0, ok_a},   64'(eok_a));
    check({tag, "_drop_a"}, {48'd0, drop_a}, 64'(edrop_a));
    check({tag, "_irq_a"},  64'(irq_cnt_a),  64'(eok_a));
    check({tag, "_ok_b"},   {48'd0, ok_b},   64'(eok_b));
    check({tag, "_drop_b"}, {48'd0, drop_b}, 64'(edrop_b));
    check({tag, "_irq_b"},  64'(irq_cnt_b),  64'(eok_b));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pkt[$];
    rst = 1'b1; rx_v = 1'b0; rx_d = 8'h00; rd_ready = 1'b1; toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_a", {63'd0, rd_valid_a}, 64'd0);
    check("rst_data_a",  {32'd0, rd_data_a},  64'd0);
    check("rst_valid_b", {63'd0, rd_valid_b}, 64'd0);
    check_counts("rst", 0, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: six bytes -> one full word and a two-byte tail
    exp_a.push_back(ent(1'b0, 2'd3, 32'h44332211));
    exp_a.push_back(ent(1'b1, 2'd1, 32'h00006655));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h44332211));
    exp_b.push_back(ent(1'b1, 2'd1, 32'h00006655));
    pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send(pkt, 2);
    wait_drain();
    check_counts("t1", 1, 0, 1, 0);

    // 2: exactly one word
    exp_a.push_back(ent(1'b1, 2'd3, 32'hDDCCBBAA));
    exp_b.push_back(ent(1'b1, 2'd3, 32'hDDCCBBAA));
    pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send(pkt, 2);
    wait_drain();
    check_counts("t2", 2, 0, 2, 0);

    // 3: stalled reader; the 4-word instance cannot hold the second datagram
    rd_ready = 1'b0;
    exp_a.push_back(ent(1'b0, 2'd3, 32'h04030201));
    exp_a.push_back(ent(1'b1, 2'd3, 32'h08070605));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h04030201));
    exp_b.push_back(ent(1'b1, 2'd3, 32'h08070605));
    pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send(pkt, 1);
    exp_b.push_back(ent(1'b0, 2'd3, 32'h13121110));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h17161514));
    exp_b.push_back(ent(1'b1, 2'd3, 32'h1B1A1918));
    pkt = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
           8'h18, 8'h19, 8'h1A, 8'h1B};
    send(pkt, 2);
    check_counts("t3", 3, 1, 4, 0);
    rd_ready = 1'b1;
    wait_drain();

    // 4: back-to-back single-byte datagrams, one idle cycle apart
    exp_a.push_back(ent(1'b1, 2'd0, 32'h0000005A));
    exp_a.push_back(ent(1'b1, 2'd0, 32'h000000A5));
    exp_b.push_back(ent(1'b1, 2'd0, 32'h0000005A));
    exp_b.push_back(ent(1'b1, 2'd0, 32'h000000A5));
    pkt = {8'h5A};
    send(pkt, 1);
    pkt = {8'hA5};
    send(pkt, 2);
    wait_drain();
    check_counts("t4", 5, 1, 6, 0);

    // 5: reset mid-datagram with a committed word still pending
    rd_ready = 1'b0;
    pkt = {8'h77};
    send(pkt, 2);
    check("t5_pending_a", {63'd0, rd_valid_a}, 64'd1);
    rx_v = 1'b1; rx_d = 8'hE1; @(posedge clk); #1;
    rx_d = 8'hE2; @(posedge clk); #1;
    rx_d = 8'hE3; @(posedge clk); #1;
    rst = 1'b1;
    #1;
    irq_cnt_a = 0;
    irq_cnt_b = 0;
    check("t5_valid_a", {63'd0, rd_valid_a}, 64'd0);
    check("t5_valid_b", {63'd0, rd_valid_b}, 64'd0);
    check_counts("t5rst", 0, 0, 0, 0);
    rx_v = 1'b0; rx_d = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    exp_a.push_back(ent(1'b1, 2'd1, 32'h00000201));
    exp_b.push_back(ent(1'b1, 2'd1, 32'h00000201));
    pkt = {8'h01, 8'h02};
    send(pkt, 2);
    wait_drain();
    check_counts("t5", 1, 0, 1, 0);

    // 6: 40 bytes with a toggling reader; only the 64-word instance fits it
    pkt = {};
    for (int i = 0; i < 40; i++) pkt.push_back(8'(i + 8'h40));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h43424140));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h47464544));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h4B4A4948));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h4F4E4D4C));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h53525150));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h57565554));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h5B5A5958));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h5F5E5D5C));
    exp_b.push_back(ent(1'b0, 2'd3, 32'h63626160));
    exp_b.push_back(ent(1'b1, 2'd3, 32'h67666564));
    toggle = 1'b1;
    send(pkt, 4);
    toggle = 1'b0;
    rd_ready = 1'b1;
    wait_drain();
    check_counts("t6", 1, 1, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
